// File: rtl/dual_prime_vector_pkg.sv
// Shared MPEG-2 definitions for the dual-prime vector block: picture structure
// codes, FSM state type and the dmvector code decoder.
package mpeg_pkg;

  localparam logic [1:0] PICT_RSVD   = 2'd0;
  localparam logic [1:0] PICT_TOP    = 2'd1;
  localparam logic [1:0] PICT_BOTTOM = 2'd2;
  localparam logic [1:0] PICT_FRAME  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARSE,
    S_CALC_X,
    S_CALC_Y,
    S_DONE
  } dp_state_t;

  typedef struct packed {
    logic signed [1:0] d0;
    logic signed [1:0] d1;
    logic [2:0]        len;
  } dmv_code_t;

  // Two back-to-back dmvector codes: '0' -> 0, '11' -> -1, '10' -> +1.
  function automatic dmv_code_t decode_dmv(input logic [3:0] b);
    dmv_code_t c;
    c.d0  = 2'sb00;
    c.d1  = 2'sb00;
    c.len = 3'd2;
    if (!b[3]) begin
      if (b[2]) begin
        c.d1  = b[1] ? 2'sb11 : 2'sb01;
        c.len = 3'd3;
      end
    end else begin
      c.d0 = b[2] ? 2'sb11 : 2'sb01;
      if (b[1]) begin
        c.d1  = b[0] ? 2'sb11 : 2'sb01;
        c.len = 3'd4;
      end else begin
        c.len = 3'd3;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/dual_prime_vector_if.sv
// Request/response bundle of the dual-prime vector block.
interface dual_prime_vector_if #(parameter int W = 32);
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] mv_x;
  logic signed [W-1:0] mv_y;
  logic [3:0]          dmv_bits;
  logic [1:0]          picture_structure;
  logic                top_field_first;
  logic signed [W-1:0] dmv_0_0;
  logic signed [W-1:0] dmv_0_1;
  logic signed [W-1:0] dmv_1_0;
  logic signed [W-1:0] dmv_1_1;
  logic [2:0]          dmv_len;
  logic                err;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_valid, mv_x, mv_y, dmv_bits, picture_structure, top_field_first, out_ready,
    input  in_ready, dmv_0_0, dmv_0_1, dmv_1_0, dmv_1_1, dmv_len, err, out_valid
  );

  modport slave (
    input  in_valid, mv_x, mv_y, dmv_bits, picture_structure, top_field_first, out_ready,
    output in_ready, dmv_0_0, dmv_0_1, dmv_1_0, dmv_1_1, dmv_len, err, out_valid
  );
endinterface

// File: rtl/dual_prime_vector_dmv_scale.sv
// Dual-prime scaling (k*mv + (mv>0)) >>> 1 for both k=1 and k=3 of one
// component; evaluated two bits wider so 3*mv cannot overflow.
module dmv_scale #(parameter int W = 32) (
  input  logic signed [W-1:0] mv,
  output logic signed [W-1:0] s1,
  output logic signed [W-1:0] s3
);

  logic signed [W+1:0] ext;
  logic signed [W+1:0] rnd;

  // NOTE: combinational blocks use blocking '=' and assign every output on every
  // path, so no latch is inferred.
  always_comb begin
    ext = {{2{mv[W-1]}}, mv};
    rnd = {{(W+1){1'b0}}, (~mv[W-1] & (|mv))};
    s1  = W'((ext + rnd) >>> 1);
    s3  = W'(((ext <<< 1) + ext + rnd) >>> 1);
  end

endmodule

// File: rtl/dual_prime_vector.sv
// MPEG-2 dual-prime derivation: decodes the two dmvector codes and forms the
// four DMV vectors, x components in one cycle and y components in the next.
module dual_prime_vector
  import mpeg_pkg::*;
#(
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst,
  dual_prime_vector_if.slave bus
);

  dp_state_t state, state_nxt;

  logic signed [W-1:0] cap_x, cap_y;
  logic [3:0]          cap_bits;
  logic [1:0]          cap_ps;
  logic                cap_tff;
  logic signed [1:0]   d0, d1;

  logic signed [W-1:0] dmv_0_0_q, dmv_0_1_q, dmv_1_0_q, dmv_1_1_q;
  logic [2:0]          dmv_len_q;
  logic                err_q;

  logic signed [W-1:0] scale_in, s1, s3;
  logic signed [W-1:0] d_ext, off0, off1, f0, f1;
  logic signed [1:0]   d_sel;
  logic                is_frame, fld0_en, f0_k3;
  dmv_code_t           code;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (bus.in_valid) state_nxt = S_PARSE;
      S_PARSE:  state_nxt = S_CALC_X;
      S_CALC_X: state_nxt = S_CALC_Y;
      S_CALC_Y: state_nxt = S_DONE;
      S_DONE:   if (bus.out_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);

  // ---------------- capture and decode ----------------
  // NOTE: pure datapath registers carry no reset; the FSM guarantees they are
  // written before they are consumed.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.in_valid) begin
      cap_x    <= bus.mv_x;
      cap_y    <= bus.mv_y;
      cap_bits <= bus.dmv_bits;
      cap_ps   <= bus.picture_structure;
      cap_tff  <= bus.top_field_first;
    end
    if (state == S_PARSE) begin
      d0 <= code.d0;
      d1 <= code.d1;
    end
  end

  assign code = decode_dmv(cap_bits);

  // ---------------- shared scaler ----------------
  assign scale_in = (state == S_CALC_Y) ? cap_y : cap_x;

  dmv_scale #(.W(W)) u_scale (
    .mv (scale_in),
    .s1 (s1),
    .s3 (s3)
  );

  // Field 0 takes k=3 only for a bottom-field-first frame; field 1 takes the other k.
  always_comb begin
    is_frame = (cap_ps == PICT_FRAME);
    fld0_en  = (cap_ps != PICT_RSVD);
    f0_k3    = is_frame && !cap_tff;
    d_sel    = (state == S_CALC_Y) ? d1 : d0;
    d_ext    = {{(W-2){d_sel[1]}}, d_sel};
    off0     = '0;
    off1     = '0;
    if (state == S_CALC_Y) begin
      off0 = (cap_ps == PICT_BOTTOM) ? W'(1) : {W{1'b1}};
      off1 = W'(1);
    end
    f0 = (f0_k3 ? s3 : s1) + d_ext + off0;
    f1 = (f0_k3 ? s1 : s3) + d_ext + off1;
  end

  // ---------------- result registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      dmv_0_0_q <= '0;
      dmv_0_1_q <= '0;
      dmv_1_0_q <= '0;
      dmv_1_1_q <= '0;
      dmv_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_PARSE: begin
          dmv_len_q <= code.len;
          err_q     <= (cap_ps == PICT_RSVD);
        end
        S_CALC_X: begin
          dmv_0_0_q <= fld0_en  ? f0 : '0;
          dmv_1_0_q <= is_frame ? f1 : '0;
        end
        S_CALC_Y: begin
          dmv_0_1_q <= fld0_en  ? f0 : '0;
          dmv_1_1_q <= is_frame ? f1 : '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.dmv_0_0 = dmv_0_0_q;
  assign bus.dmv_0_1 = dmv_0_1_q;
  assign bus.dmv_1_0 = dmv_1_0_q;
  assign bus.dmv_1_1 = dmv_1_1_q;
  assign bus.dmv_len = dmv_len_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_dual_prime_vector.sv
// Table-driven bench for dual_prime_vector with an expected-result queue,
// plus backpressure and mid-operation reset sequences.
module tb_dual_prime_vector;

  typedef struct {
    logic [1:0]  ps;
    logic        tff;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  bits;
    logic [31:0] d00, d01, d10, d11;
    logic [2:0]  len;
    logic        err;
  } vec_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[9];
  vec_t sb[$];

  dual_prime_vector_if #(.W(32)) bus ();

  dual_prime_vector #(.W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] ps, input logic tff, input int x, input int y,
                              input logic [3:0] bits, input int d00, input int d01,
                              input int d10, input int d11, input int len, input logic err);
    vec_t v;
    v.ps = ps; v.tff = tff; v.x = x; v.y = y; v.bits = bits;
    v.d00 = d00; v.d01 = d01; v.d10 = d10; v.d11 = d11;
    v.len = 3'(len); v.err = err;
    return v;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"},  32'(bus.in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_dmv_or"},    bus.dmv_0_0 | bus.dmv_0_1 | bus.dmv_1_0 | bus.dmv_1_1, 32'd0);
    check({tag, "_len_err"},   32'({bus.dmv_len, bus.err}), 32'd0);
  endtask

  task automatic drive_req(input vec_t v);
    bus.in_valid          = 1'b1;
    bus.picture_structure = v.ps;
    bus.top_field_first   = v.tff;
    bus.mv_x              = v.x;
    bus.mv_y              = v.y;
    bus.dmv_bits          = v.bits;
  endtask

  task automatic scramble_inputs();
    bus.in_valid          = 1'b0;
    bus.picture_structure = 2'($urandom());
    bus.top_field_first   = 1'($urandom());
    bus.mv_x              = $urandom();
    bus.mv_y              = $urandom();
    bus.dmv_bits          = 4'($urandom());
  endtask

  // Issue one request, wait (bounded) for out_valid, compare against the queue head.
  task automatic send(input vec_t v, input logic rdy, input string tag);
    vec_t e;
    int   edges;
    @(negedge clk);
    drive_req(v);
    bus.out_ready = rdy;
    check({tag, "_accept_ready"}, 32'(bus.in_ready), 32'd1);
    sb.push_back(v);
    @(negedge clk);
    scramble_inputs();
    edges = 1;
    check({tag, "_busy"}, 32'({bus.in_ready, bus.out_valid}), 32'd0);
    while (!bus.out_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    check({tag, "_latency"}, 32'(edges), 32'd4);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_dmv_0_0"}, bus.dmv_0_0, e.d00);
      check({tag, "_dmv_0_1"}, bus.dmv_0_1, e.d01);
      check({tag, "_dmv_1_0"}, bus.dmv_1_0, e.d10);
      check({tag, "_dmv_1_1"}, bus.dmv_1_1, e.d11);
      check({tag, "_dmv_len"}, 32'(bus.dmv_len), 32'(e.len));
      check({tag, "_err"},     32'(bus.err), 32'(e.err));
    end
  endtask

  initial begin
    vecs[0] = mk(2'd3, 1'b1,  5, -3, 4'b1100,  2, -3,  7, -4, 3, 1'b0);
    vecs[1] = mk(2'd3, 1'b0,  2,  0, 4'b0000,  3, -1,  1,  1, 2, 1'b0);
    vecs[2] = mk(2'd1, 1'b0, -4,  7, 4'b0100, -2,  4,  0,  0, 3, 1'b0);
    vecs[3] = mk(2'd2, 1'b0, -4,  7, 4'b0100, -2,  6,  0,  0, 3, 1'b0);
    vecs[4] = mk(2'd0, 1'b0,  9, -9, 4'b1010,  0,  0,  0,  0, 4, 1'b1);
    vecs[5] = mk(2'd3, 1'b1, -1,  1, 4'b1011,  0, -1, -1,  2, 4, 1'b0);
    vecs[6] = mk(2'd3, 1'b1, 32'h7FFFFFFF, 32'h80000000, 4'b0000,
                 32'h40000000, 32'hBFFFFFFF, 32'hBFFFFFFF, 32'h40000001, 2, 1'b0);
    vecs[7] = mk(2'd2, 1'b1,  3, -1, 4'b1110,  1,  1,  0,  0, 4, 1'b0);
    vecs[8] = mk(2'd3, 1'b0, -5,  3, 4'b0111, -8,  3, -3,  2, 3, 1'b0);

    rst = 1'b1;
    bus.out_ready = 1'b0;
    scramble_inputs();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Table vectors with out_ready held high: DONE lasts one cycle.
    for (int i = 0; i < 9; i++) begin
      send(vecs[i], 1'b1, $sformatf("vec%0d", i));
      @(negedge clk);
      check($sformatf("vec%0d_post_hs", i), 32'({bus.in_ready, bus.out_valid}), 32'b10);
    end

    // Backpressure: results frozen, a request during DONE is ignored.
    send(vecs[0], 1'b0, "bp");
    for (int c = 0; c < 10; c++) begin
      if (c == 3) drive_req(vecs[2]);
      @(negedge clk);
      if (c == 3) scramble_inputs();
      check("bp_hold", 32'({bus.out_valid, bus.in_ready}), 32'b10);
      check("bp_dmv_0_0", bus.dmv_0_0, vecs[0].d00);
      check("bp_dmv_1_1", bus.dmv_1_1, vecs[0].d11);
      check("bp_len", 32'(bus.dmv_len), 32'(vecs[0].len));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("bp_no_extra_out", 32'(bus.out_valid), 32'd0);
    end

    // Reset while in S_CALC_X aborts the operation.
    @(negedge clk);
    drive_req(vecs[5]);
    @(negedge clk);
    scramble_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midrst");
    @(negedge clk);
    check_reset_state("midrst_hold");
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_out", 32'(bus.out_valid), 32'd0);
    end

    // Normal operation resumes after the abort.
    send(vecs[8], 1'b1, "after_rst");
    @(negedge clk);
    check("after_rst_post_hs", 32'({bus.in_ready, bus.out_valid}), 32'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dual_prime_vector.md
# dual_prime_vector

Downstream consumer of the motion-vector decode stage in the MPEG-2 macroblock path. When a macroblock uses dual-prime prediction, it takes the decoded base vector (`PMV[0][0][*]`) and the next bits of the bitstream window. It decodes the two `dmvector` codes and computes the four derived vectors `DMV[0..1][0..1]`. It also reports how many bits it consumed, so the controller can flush the bit buffer.

## Interface
Parameters:
- `W`, 32 — width of vector inputs and outputs, signed two's complement.

Ports:
- `clk` in 1 — clock.
- `rst` in 1 — reset, synchronous, active-high.
- `in_valid` in 1 — request; sampled only while `in_ready`=1.
- `in_ready` out 1 — block idle and able to accept.
- `mv_x` in W — signed horizontal base vector.
- `mv_y` in W — signed vertical base vector, already field-scaled upstream.
- `dmv_bits` in 4 — bitstream window, MSB = next unread bit.
- `picture_structure` in 2 — 1=TOP, 2=BOTTOM, 3=FRAME, 0=reserved.
- `top_field_first` in 1 — frame pictures only.
- `dmv_0_0`, `dmv_0_1`, `dmv_1_0`, `dmv_1_1` out W — derived vectors as `[field][x/y]`.
- `dmv_len` out 3 — bits consumed from `dmv_bits`, range 2..4.
- `err` out 1 — reserved `picture_structure` seen.
- `out_valid` out 1 — results valid and held.
- `out_ready` in 1 — consumer accepts.

## Operation
- FSM states: S_IDLE → S_PARSE → S_CALC_X → S_CALC_Y → S_DONE → S_IDLE.
- S_IDLE: `in_ready`=1. On `in_valid`, capture all inputs and go to S_PARSE.
- S_PARSE: decode `dmvector[0]` from the window starting at bit 3.
  - First bit 0 → value 0, length 1.
  - First bits 1,1 → value −1, length 2.
  - First bits 1,0 → value +1, length 2.
  - `dmvector[1]` is decoded the same way from the next unread bit. `dmv_len` = sum of the two lengths.
- Scaling function `scale(k, mv)` = (k·mv + (mv>0 ? 1 : 0)) >>> 1, with k ∈ {1, 3}.
  - Evaluate in W+2 bits, sign-extended; `>>>` is arithmetic (floor).
  - Truncate the result to W bits.
- S_CALC_X computes the x components; S_CALC_Y computes the y components. One shared scaling unit, one component pair per cycle.
- FRAME, `top_field_first`=1:
  - `dmv_0_0` = scale(1,x)+d0.
  - `dmv_0_1` = scale(1,y)+d1−1.
  - `dmv_1_0` = scale(3,x)+d0.
  - `dmv_1_1` = scale(3,y)+d1+1.
- FRAME, `top_field_first`=0: swap k between field 0 and field 1. Offsets are unchanged (−1 on `dmv_0_1`, +1 on `dmv_1_1`).
- TOP field:
  - `dmv_0_0` = scale(1,x)+d0.
  - `dmv_0_1` = scale(1,y)+d1−1.
  - `dmv_1_*` = 0.
- BOTTOM field: same as TOP, but `dmv_0_1` uses +1.
- Reserved (0): all `dmv_*` = 0, `err`=1. `dmv_len` is still decoded.
- S_DONE: `out_valid`=1; outputs held stable. On `out_ready`=1, go to S_IDLE.

## Timing
- Reset: state S_IDLE; `in_ready`=1 one cycle after the reset edge, and held at 1 throughout while `rst` is asserted. All of the following are 0: `out_valid`, `err`, `dmv_len`, every `dmv_*`.
- Accept edge = edge where `in_valid`&`in_ready`. `out_valid` rises after the 3rd edge following it; fixed latency is 4 edges, including the accept edge.
- `in_ready` is 0 from the accept edge until the edge that completes the output handshake. No new request is taken on that same edge, so throughput is at most one vector per 5 cycles.
- `in_valid` while busy: ignored, no queuing.
- `out_ready` held high: S_DONE lasts exactly one cycle.
- `out_ready` low: outputs and `err` stay frozen indefinitely.
- Inputs other than at the accept edge: don't-care; captured copies are used.
- `rst` mid-operation: abort on that edge, restore reset values, no output emitted.
- Outputs are registered; none is combinational from inputs.

## Structure
- Shared package `mpeg_pkg`:
  - `PICT_TOP`=1, `PICT_BOTTOM`=2, `PICT_FRAME`=3.
  - FSM state enum `dp_state_t`.
- Sub-module `dmv_scale`: combinational scale(k, mv) for k ∈ {1, 3}. One instance, time-shared between x and y.

## Test plan
- FRAME, tff=1, x=5, y=−3, bits 1100 → d=(−1,0), len=3; DMV = 2, −3, 7, −4.
- FRAME, tff=0, x=2, y=0, bits 0000 → len=2; DMV = 3, −1, 1, 1.
- TOP, x=−4, y=7, bits 0100 → d=(0,+1), len=3; DMV = −2, 4, 0, 0. Same stimulus with BOTTOM → `dmv_0_1`=6.
- Backpressure: hold `out_ready`=0 for 10 cycles → `out_valid` and values stable, `in_ready`=0, and a second `in_valid` is ignored.
- Reset asserted in S_CALC_X → next cycle `in_ready`=1, `out_valid`=0, all outputs 0.
- `picture_structure`=0, bits 1010 → `err`=1, all DMV 0, len=4; fixed 4-edge latency checked on every case.
